decoy_gen_multi: RTL and testbench
==================================

DECOY_GEN_MULTI -- requirements
Module: decoy_gen_multi

Interface
REQ-001 SHALL have parameter RNG_W, default 4, width of the random value.
REQ-002 SHALL have parameter N_LEVELS, default 3, range 2..4, number of intensity levels.
REQ-003 SHALL have parameter PULSE_W, default 8, width of the pulse-length field.
REQ-004 SHALL have parameter CNT_W, default 32, width of the per-level statistics counters.
REQ-005 SHALL have one clock and one reset: clk240 in 1, the single clock; rst_240 in 1, reset, asynchronous, active-high.
REQ-006 SHALL have decoy_rst in 1, synchronous soft reset, active-high.
REQ-007 SHALL have pps_i in 1, asynchronous PPS input.
REQ-008 SHALL have pps_trigger in 1, level arm enable.
REQ-009 SHALL have rng_value in RNG_W, random sample.
REQ-010 SHALL have rd_en_4 in 1, single-cycle strobe qualifying rng_value.
REQ-011 SHALL have thr in (N_LEVELS-1)*RNG_W, level thresholds; slice k = thr[k].
REQ-012 SHALL have pulse_len in PULSE_W; value 0 = hold mode.
REQ-013 SHALL have decoy_signal out 1, high while a decoy (level != 0) pulse is active.
REQ-014 SHALL have decoy_level out 2, level of the current pulse.
REQ-015 SHALL have decoy_valid out 1, high while any pulse is active.
REQ-016 SHALL have running out 1, high in state RUN.
REQ-017 SHALL have level_cnt out N_LEVELS*CNT_W, per-level counts snapshotted at the last PPS edge.

Function
REQ-018 SHALL synchronise pps_i through 2 flops; pps_rise SHALL be a 1-cycle pulse when sync stage 2 = 1 and its previous value = 0.
REQ-019 SHALL implement states IDLE, ARMED, RUN: IDLE->ARMED when pps_trigger=1; ARMED->RUN on pps_rise; ARMED->IDLE if pps_trigger=0; RUN->IDLE when pps_trigger=0, effective next cycle.
REQ-020 SHALL ignore rd_en_4 outside RUN, including the cycle RUN is entered.
REQ-021 SHALL map a sample in RUN to level = smallest k with rng_value < thr[k], else N_LEVELS-1; comparisons unsigned; non-monotonic thr still follows this rule.
REQ-022 SHALL register the outputs: decoy_valid, decoy_level and decoy_signal update 1 cycle after the rd_en_4 cycle.
REQ-023 SHALL keep a pulse active for exactly pulse_len cycles when pulse_len > 0, or until the next accepted strobe when pulse_len = 0.
REQ-024 SHALL restart a pulse when a new strobe arrives during it: new level, full length, no idle gap.
REQ-025 SHALL sample pulse_len at each strobe; changes mid-pulse SHALL NOT affect the current pulse.
REQ-026 SHALL increment per-level counter[level] per accepted strobe, saturating at 2^CNT_W-1.
REQ-027 SHALL, on pps_rise in RUN, copy the counters to level_cnt and clear them; a strobe in the same cycle SHALL count into the new interval.
REQ-028 SHALL force decoy_valid, decoy_signal and decoy_level to 0 in IDLE and ARMED.

Reset
REQ-029 SHALL, on rst_240 (async), set state IDLE, all outputs 0, counters and level_cnt 0, and synchroniser flops 0.
REQ-030 SHALL, on decoy_rst (sync), act as rst_240 from the next edge, dominating all other events in that cycle, including a mid-pulse reset.

Structure
REQ-031 SHALL place the state enum, level width (2) and parameter defaults in package decoy_pkg.
REQ-032 SHALL use sub-module pps_sync_edge for the synchroniser and rising-edge detection.
REQ-033 SHALL be 120-400 lines of RTL and free of latches.

Verification (N_LEVELS=3, thr0=6, thr1=12, pulse_len=3)
REQ-034 SHALL check: pps_trigger=1, then pps_i rises -> running=1 within 3-4 cycles; rd_en_4 before that has no effect.
REQ-035 SHALL check: strobes with rng 1, 7, 13 spaced 5 cycles apart -> decoy_level 0, 1, 2; decoy_signal 0, 1, 1; each pulse 3 cycles starting 1 cycle after its strobe.
REQ-036 SHALL check: with pulse_len=0, strobes rng=7 then rng=2 six cycles later -> decoy_valid held 6 cycles at level 1, then level 0 with no gap.
REQ-037 SHALL check: 10 strobes at rng=13 then pps_rise -> level_cnt[2]=10 and others 0; a strobe in the pps_rise cycle -> new counter=1.
REQ-038 SHALL check: decoy_rst mid-pulse -> all outputs 0 next cycle, state IDLE, level_cnt 0; rst_240 asserted asynchronously -> same result without a clock edge.
REQ-039 SHALL check: pps_trigger dropped in RUN -> running=0 and decoy_valid=0 next cycle, and later strobes are ignored.

Source files
------------

// File: rtl/decoy_pkg.sv
// decoy_pkg -- shared types and constants for the decoy-state pulse generator.
//   state_t      : controller states (IDLE, ARMED, RUN)
//   LEVEL_W      : width of the intensity-level code carried on decoy_level
//   *_DEF        : default values for the generator parameters
package decoy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int LEVEL_W      = 2;

    localparam int RNG_W_DEF    = 4;
    localparam int N_LEVELS_DEF = 3;
    localparam int PULSE_W_DEF  = 8;
    localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/decoy_gen_multi_if.sv
// decoy_gen_multi_if -- sample-in / pulse-out bundle of the decoy generator.
//   rng_value    : random sample (RNG_W bits), qualified by rd_en_4
//   rd_en_4      : single-cycle strobe, one accepted sample per high cycle
//   decoy_signal : high while a pulse with a non-zero level is active
//   decoy_level  : level of the current pulse (0 when no pulse)
//   decoy_valid  : high while any pulse is active
// The master modport is the sample source / pulse consumer; the generator
// itself connects through the slave modport.
interface decoy_gen_multi_if #(
    parameter int RNG_W = decoy_pkg::RNG_W_DEF
) ();
    import decoy_pkg::*;

    logic [RNG_W-1:0]   rng_value;
    logic               rd_en_4;
    logic               decoy_signal;
    logic [LEVEL_W-1:0] decoy_level;
    logic               decoy_valid;

    modport master (
        output rng_value,
        output rd_en_4,
        input  decoy_signal,
        input  decoy_level,
        input  decoy_valid
    );

    modport slave (
        input  rng_value,
        input  rd_en_4,
        output decoy_signal,
        output decoy_level,
        output decoy_valid
    );

endinterface

// File: rtl/decoy_gen_multi_pps_sync_edge.sv
// pps_sync_edge -- two-flop synchroniser plus rising-edge detector for the
// asynchronous PPS input.
//   clk      : destination clock
//   rst      : asynchronous active-high reset
//   soft_rst : synchronous active-high reset, same effect as rst
//   async_in : asynchronous input
//   rise     : one-cycle pulse when the synchronised level goes 0 -> 1
module pps_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic soft_rst,
    input  logic async_in,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else if (soft_rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            // stage 1 may go metastable; stage 2 is the clean level
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            // previous clean level, for edge detection
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/decoy_gen_multi.sv
// decoy_gen_multi -- decoy-state intensity pulse generator.
// Once armed by pps_trigger and started by a PPS edge, each accepted random
// sample is mapped to an intensity level via the threshold set and drives a
// pulse of pulse_len cycles (or held until the next sample when pulse_len=0).
// Per-level sample counts are snapshotted and cleared at each PPS edge.
//   clk240      : clock
//   rst_240     : asynchronous active-high reset
//   decoy_rst   : synchronous active-high soft reset (acts like rst_240)
//   pps_i       : asynchronous PPS input
//   pps_trigger : level arm enable; dropping it returns to IDLE
//   thr         : N_LEVELS-1 thresholds, slice k = thr[k*RNG_W +: RNG_W]
//   pulse_len   : pulse length in cycles, 0 = hold until next sample
//   bus         : rng_value/rd_en_4 in, decoy_signal/level/valid out
//   running     : high in RUN
//   level_cnt   : per-level counts captured at the last PPS edge in RUN
module decoy_gen_multi
    import decoy_pkg::*;
#(
    parameter int RNG_W    = RNG_W_DEF,
    parameter int N_LEVELS = N_LEVELS_DEF,
    parameter int PULSE_W  = PULSE_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                          clk240,
    input  logic                          rst_240,
    input  logic                          decoy_rst,
    input  logic                          pps_i,
    input  logic                          pps_trigger,
    input  logic [(N_LEVELS-1)*RNG_W-1:0] thr,
    input  logic [PULSE_W-1:0]            pulse_len,
    decoy_gen_multi_if.slave              bus,
    output logic                          running,
    output logic [N_LEVELS*CNT_W-1:0]     level_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic               pps_rise;
    logic               accept;
    logic               keep_run;
    logic               snap;
    logic [RNG_W-1:0]   rng;
    logic [LEVEL_W-1:0] lvl;

    logic               valid_q;
    logic               signal_q;
    logic [LEVEL_W-1:0] level_q;
    logic               hold_q;
    logic [PULSE_W-1:0] rem_q;

    logic [CNT_W-1:0]   cnt [N_LEVELS];

    pps_sync_edge u_pps (
        .clk      (clk240),
        .rst      (rst_240),
        .soft_rst (decoy_rst),
        .async_in (pps_i),
        .rise     (pps_rise)
    );

    // controller state register
    always_ff @(posedge clk240 or posedge rst_240) begin
        if (rst_240) begin
            state <= ST_IDLE;
        end else if (decoy_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ARMED drops back to IDLE ahead of a coincident PPS edge when the
    // trigger is removed.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pps_trigger) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!pps_trigger)  state_nxt = ST_IDLE;
                else if (pps_rise) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!pps_trigger) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign running  = (state == ST_RUN);
    // samples only count from the first full cycle spent in RUN
    assign accept   = (state == ST_RUN) && bus.rd_en_4;
    assign keep_run = (state_nxt == ST_RUN);
    assign snap     = (state == ST_RUN) && pps_rise;
    assign rng      = bus.rng_value;

    // Lowest matching threshold wins, scanning from the top down so the
    // last assignment is the smallest k; thresholds need not be monotonic.
    always_comb begin
        lvl = LEVEL_W'(N_LEVELS - 1);
        for (int k = N_LEVELS - 2; k >= 0; k--) begin
            if (rng < thr[k*RNG_W +: RNG_W]) lvl = LEVEL_W'(k);
        end
    end

    // pulse output stage: registered one cycle after the accepted sample
    always_ff @(posedge clk240 or posedge rst_240) begin
        if (rst_240) begin
            valid_q  <= 1'b0;
            signal_q <= 1'b0;
            level_q  <= '0;
            hold_q   <= 1'b0;
            rem_q    <= '0;
        end else if (decoy_rst || !keep_run) begin
            // outputs are silent whenever the next state is not RUN
            valid_q  <= 1'b0;
            signal_q <= 1'b0;
            level_q  <= '0;
            hold_q   <= 1'b0;
            rem_q    <= '0;
        end else if (accept) begin
            // restart with the sampled length; rem_q counts cycles left
            // after the first one, so a length of N gives N active cycles
            valid_q  <= 1'b1;
            signal_q <= (lvl != '0);
            level_q  <= lvl;
            hold_q   <= (pulse_len == '0);
            rem_q    <= pulse_len - PULSE_W'(1);
        end else if (valid_q && !hold_q) begin
            if (rem_q == '0) begin
                valid_q  <= 1'b0;
                signal_q <= 1'b0;
                level_q  <= '0;
            end else begin
                rem_q <= rem_q - PULSE_W'(1);
            end
        end
    end

    assign bus.decoy_valid  = valid_q;
    assign bus.decoy_signal = signal_q;
    assign bus.decoy_level  = level_q;

    // statistics: a sample coinciding with the snapshot opens the new
    // interval with a count of one
    always_ff @(posedge clk240 or posedge rst_240) begin
        if (rst_240) begin
            level_cnt <= '0;
            for (int k = 0; k < N_LEVELS; k++) cnt[k] <= '0;
        end else if (decoy_rst) begin
            level_cnt <= '0;
            for (int k = 0; k < N_LEVELS; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_LEVELS; k++) begin
                if (snap) level_cnt[k*CNT_W +: CNT_W] <= cnt[k];
                if (accept && (lvl == LEVEL_W'(k))) begin
                    cnt[k] <= snap ? CNT_W'(1) : sat_inc(cnt[k]);
                end else if (snap) begin
                    cnt[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoy_gen_multi.sv
module tb_decoy_gen_multi;

    localparam int RNG_W    = 4;
    localparam int N_LEVELS = 3;
    localparam int PULSE_W  = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = 15;

    logic clk240 = 1'b0;
    always #5 clk240 = ~clk240;

    logic                          rst_240;
    logic                          decoy_rst;
    logic                          pps_i;
    logic                          pps_trigger;
    logic [(N_LEVELS-1)*RNG_W-1:0] thr;
    logic [PULSE_W-1:0]            pulse_len;
    logic                          running;
    logic [N_LEVELS*CNT_W-1:0]     level_cnt;

    decoy_gen_multi_if #(.RNG_W(RNG_W)) bus ();

    decoy_gen_multi #(
        .RNG_W    (RNG_W),
        .N_LEVELS (N_LEVELS),
        .PULSE_W  (PULSE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk240      (clk240),
        .rst_240     (rst_240),
        .decoy_rst   (decoy_rst),
        .pps_i       (pps_i),
        .pps_trigger (pps_trigger),
        .thr         (thr),
        .pulse_len   (pulse_len),
        .bus         (bus),
        .running     (running),
        .level_cnt   (level_cnt)
    );

    typedef struct {
        int rng;
        int th0;
        int th1;
        int lvl;
    } vec_t;

    vec_t tbl [14];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int  th [N_LEVELS-1];
    int  mcnt [N_LEVELS];
    int  msnap [N_LEVELS];
    bit  model_run;

    int  c, s_cyc, s_len, s_lvl, v;
    bit  have, active;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk240);
        #1;
    endtask

    task automatic set_thr(input int a, input int b);
        th[0] = a;
        th[1] = b;
        thr   = {4'(b), 4'(a)};
    endtask

    function automatic int ref_level(input int val);
        for (int k = 0; k < N_LEVELS - 1; k++)
            if (val < th[k]) return k;
        return N_LEVELS - 1;
    endfunction

    task automatic model_count(input int val);
        int l;
        l = ref_level(val);
        if (mcnt[l] < CNT_MAX) mcnt[l]++;
    endtask

    task automatic do_strobe(input int val);
        bus.rng_value = 4'(val);
        bus.rd_en_4   = 1'b1;
        tick();
        bus.rd_en_4   = 1'b0;
        if (model_run) model_count(val);
    endtask

    task automatic check_out(input string name, input bit ev, input int el, input bit es);
        chk({name, ".valid"},  bus.decoy_valid,  ev);
        chk({name, ".level"},  bus.decoy_level,  el);
        chk({name, ".signal"}, bus.decoy_signal, es);
    endtask

    task automatic check_snap(input string name);
        for (int k = 0; k < N_LEVELS; k++)
            chk($sformatf("%s.cnt%0d", name, k), level_cnt[k*CNT_W +: CNT_W], msnap[k]);
    endtask

    // PPS edge while in RUN; optionally a strobe in the detected-edge cycle
    task automatic pps_pulse(input bit strobe, input int val);
        pps_i = 1'b1;
        tick();
        tick();
        if (strobe) begin
            bus.rng_value = 4'(val);
            bus.rd_en_4   = 1'b1;
        end
        tick();
        bus.rd_en_4 = 1'b0;
        for (int k = 0; k < N_LEVELS; k++) begin
            msnap[k] = mcnt[k];
            mcnt[k]  = 0;
        end
        if (strobe) model_count(val);
        pps_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic enter_run();
        pps_trigger = 1'b1;
        tick();
        pps_i = 1'b1;
        repeat (3) tick();
        pps_i = 1'b0;
        repeat (3) tick();
        model_run = 1'b1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N_LEVELS; k++) begin
            mcnt[k]  = 0;
            msnap[k] = 0;
        end
        model_run = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 6, 12, 0};
        tbl[1]  = '{5, 6, 12, 0};
        tbl[2]  = '{6, 6, 12, 1};
        tbl[3]  = '{7, 6, 12, 1};
        tbl[4]  = '{11, 6, 12, 1};
        tbl[5]  = '{12, 6, 12, 2};
        tbl[6]  = '{15, 6, 12, 2};
        tbl[7]  = '{0, 0, 0, 2};
        tbl[8]  = '{3, 12, 6, 0};
        tbl[9]  = '{8, 12, 6, 0};
        tbl[10] = '{12, 12, 6, 2};
        tbl[11] = '{5, 2, 6, 1};
        tbl[12] = '{0, 1, 0, 0};
        tbl[13] = '{15, 15, 15, 2};

        model_clear();
        rst_240       = 1'b1;
        decoy_rst     = 1'b0;
        pps_i         = 1'b0;
        pps_trigger   = 1'b0;
        pulse_len     = 8'd3;
        bus.rng_value = '0;
        bus.rd_en_4   = 1'b0;
        set_thr(6, 12);

        // reset state
        repeat (3) tick();
        check_out("reset", 0, 0, 0);
        chk("reset.running", running, 0);
        chk("reset.level_cnt", level_cnt, 0);
        rst_240 = 1'b0;
        tick();
        chk("idle.running", running, 0);

        // arming and start on PPS; strobes before RUN are ignored
        pps_trigger = 1'b1;
        tick();
        do_strobe(13);
        chk("armed.strobe_valid", bus.decoy_valid, 0);
        pps_i = 1'b1;
        tick();
        chk("start.running_c1", running, 0);
        tick();
        chk("start.running_c2", running, 0);
        bus.rng_value = 4'd13;
        bus.rd_en_4   = 1'b1;
        tick();
        bus.rd_en_4 = 1'b0;
        chk("start.running_c3", running, 1);
        chk("start.entry_strobe_valid", bus.decoy_valid, 0);
        tick();
        chk("start.entry_strobe_valid2", bus.decoy_valid, 0);
        pps_i = 1'b0;
        repeat (3) tick();
        model_run = 1'b1;

        // three strobes five cycles apart, pulse length 3
        for (int i = 0; i < 3; i++) begin
            int r, l;
            r = (i == 0) ? 1 : (i == 1) ? 7 : 13;
            l = i;
            do_strobe(r);
            for (int j = 1; j <= 5; j++) begin
                if (j > 1) tick();
                check_out($sformatf("pulse%0d.c%0d", i, j), j <= 3, (j <= 3) ? l : 0, (j <= 3) && (l != 0));
            end
        end

        // hold mode and gap-free restart
        pulse_len = 8'd0;
        do_strobe(7);
        for (int j = 1; j <= 6; j++) begin
            if (j > 1) tick();
            check_out($sformatf("hold.c%0d", j), 1, 1, 1);
        end
        do_strobe(2);
        check_out("hold.restart", 1, 0, 0);
        pulse_len = 8'd3;
        repeat (4) tick();
        check_out("hold.len_change_ignored", 1, 0, 0);
        do_strobe(13);
        pulse_len = 8'd0;
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) tick();
            check_out($sformatf("len3_after_hold.c%0d", j), j <= 3, (j <= 3) ? 2 : 0, j <= 3);
        end

        // level mapping table
        pulse_len = 8'd3;
        for (int i = 0; i < 14; i++) begin
            set_thr(tbl[i].th0, tbl[i].th1);
            do_strobe(tbl[i].rng);
            check_out($sformatf("tbl%0d", i), 1, tbl[i].lvl, tbl[i].lvl != 0);
            repeat (3) tick();
        end

        // randomized strobes against the timing model
        set_thr($urandom_range(0, 15), $urandom_range(0, 15));
        c    = 0;
        have = 1'b0;
        for (int i = 0; i < 150; i++) begin
            active = have && ((s_len == 0) || ((c - s_cyc) <= s_len));
            check_out($sformatf("rand%0d", i), active, active ? s_lvl : 0, active && (s_lvl != 0));
            pulse_len = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) begin
                v     = $urandom_range(0, 15);
                have  = 1'b1;
                s_cyc = c;
                s_len = int'(pulse_len);
                s_lvl = ref_level(v);
                do_strobe(v);
            end else begin
                tick();
            end
            c++;
        end
        pps_pulse(0, 0);
        check_snap("rand_snap");

        // statistics snapshot, coincident strobe and saturation
        pulse_len = 8'd3;
        set_thr(6, 12);
        repeat (10) do_strobe(13);
        pps_pulse(1, 13);
        check_snap("cnt10");
        chk("cnt10.lvl2", level_cnt[2*CNT_W +: CNT_W], 10);
        chk("cnt10.lvl0", level_cnt[0 +: CNT_W], 0);
        chk("cnt10.lvl1", level_cnt[CNT_W +: CNT_W], 0);
        pps_pulse(0, 0);
        chk("coincident.lvl2", level_cnt[2*CNT_W +: CNT_W], 1);
        chk("coincident.lvl0", level_cnt[0 +: CNT_W], 0);
        repeat (20) do_strobe(13);
        pps_pulse(0, 0);
        chk("saturate.lvl2", level_cnt[2*CNT_W +: CNT_W], CNT_MAX);
        check_snap("saturate");

        // soft reset mid-pulse, with a strobe in the same cycle
        do_strobe(13);
        check_out("softrst.pre", 1, 2, 1);
        decoy_rst     = 1'b1;
        bus.rng_value = 4'd1;
        bus.rd_en_4   = 1'b1;
        tick();
        decoy_rst   = 1'b0;
        bus.rd_en_4 = 1'b0;
        model_clear();
        check_out("softrst", 0, 0, 0);
        chk("softrst.running", running, 0);
        chk("softrst.level_cnt", level_cnt, 0);

        // asynchronous reset mid-pulse, no clock edge involved
        enter_run();
        do_strobe(7);
        do_strobe(7);
        pps_pulse(0, 0);
        check_snap("pre_async");
        pulse_len = 8'd0;
        do_strobe(13);
        check_out("async.pre", 1, 2, 1);
        #2;
        rst_240 = 1'b1;
        #1;
        check_out("async", 0, 0, 0);
        chk("async.running", running, 0);
        chk("async.level_cnt", level_cnt, 0);
        #1;
        rst_240 = 1'b0;
        model_clear();
        tick();

        // trigger dropped in RUN
        enter_run();
        pulse_len = 8'd0;
        do_strobe(13);
        check_out("drop.pre", 1, 2, 1);
        pps_trigger = 1'b0;
        tick();
        chk("drop.running", running, 0);
        chk("drop.valid", bus.decoy_valid, 0);
        model_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_strobe(13);
            chk($sformatf("drop.ignored%0d", i), bus.decoy_valid, 0);
        end
        enter_run();
        pps_pulse(0, 0);
        check_snap("drop.snap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
